// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side arbiter: FSM state encoding and burst counter width.
package fifo_rd_pkg;

    localparam int BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// FIFO read-port bundle between the consumers' FIFO-side driver (master) and the arbiter (slave).
interface fifo_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]    req;
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  r_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport master (
        output req, empty, rdata,
        input  r_en, gnt, rd_valid, rd_data, busy
    );

    modport slave (
        input  req, empty, rdata,
        output r_en, gnt, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, cyclically.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;

    // Modulo-NUM_REQ add; NUM_REQ need not be a power of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = req_i[wrap_add(rr_ptr_i, IDX_W'(i))];
    end

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign any_o = |req_i;
    assign idx_o = wrap_add(rr_ptr_i, off);

    always_comb begin
        grant_o = '0;
        if (any_o) grant_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin scheduler sharing one FIFO read port among NUM_REQ consumers.
// Define FIFO_RD_BURST_LIMIT_EN to cap each grant at BURST_MAX words; otherwise a grant runs until req drops or the FIFO empties.
module fifo_rd_arbiter
    import fifo_rd_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int IDX_W      = 2
) (
    input  logic               rclk,
    input  logic               rrst_n,
    fifo_rd_arbiter_if.slave   bus
);
    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_param
        $error("fifo_rd_arbiter: NUM_REQ must be 2..8 and BURST_MAX 1..15");
    end

    rd_state_e             state_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [IDX_W-1:0]      g_idx_q;
    logic [IDX_W-1:0]      rr_ptr_q;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  r_en;
    logic                  burst_ok;
    logic                  burst_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_gnt),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

`ifdef FIFO_RD_BURST_LIMIT_EN
    localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST_MAX);

    logic [BURST_CNT_W-1:0] burst_cnt_q;
    logic [BURST_CNT_W-1:0] burst_cnt_d;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (r_en && burst_cnt_q != BURST_LIM) burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
    end

    assign burst_ok   = (burst_cnt_q < BURST_LIM);
    // Leave on the read that fills the quota so no idle GRANT cycle is wasted.
    assign burst_done = (burst_cnt_d == BURST_LIM);
`else
    assign burst_ok   = 1'b1;
    assign burst_done = 1'b0;
`endif

    // Empty gates the read in the same cycle, so the FIFO is never read while empty.
    assign r_en = (state_q == GRANT) & bus.req[g_idx_q] & ~bus.empty & burst_ok;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            g_idx_q     <= '0;
            rr_ptr_q    <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
`ifdef FIFO_RD_BURST_LIMIT_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            rd_data_q  <= bus.rdata;
            rd_valid_q <= r_en ? gnt_q : '0;
            case (state_q)
                IDLE: begin
                    if (pick_any && !bus.empty) begin
                        gnt_q   <= pick_gnt;
                        g_idx_q <= pick_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
`ifdef FIFO_RD_BURST_LIMIT_EN
                    burst_cnt_q <= burst_cnt_d;
`endif
                    if (!r_en || burst_done) begin
                        gnt_q   <= '0;
`ifdef FIFO_RD_BURST_LIMIT_EN
                        burst_cnt_q <= '0;
`endif
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    rr_ptr_q <= (g_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx_q + IDX_W'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.r_en     = r_en;
    assign bus.gnt      = gnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter with a show-ahead FIFO model (rdata = head word, empty updated at the clock edge).
module tb_fifo_rd_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_MAX  = 4;
    localparam int IDX_W      = 2;

    typedef struct {
        int                    idx;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    logic rclk = 1'b0;
    logic rrst_n;

    fifo_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_rd_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_MAX  (BURST_MAX),
        .IDX_W      (IDX_W)
    ) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus.slave)
    );

    always #5 rclk = ~rclk;

    exp_t                  exp_q[$];
    logic [DATA_WIDTH-1:0] fifo_q[$];
    logic [DATA_WIDTH-1:0] pending_q[$];
    logic [DATA_WIDTH-1:0] next_word = 8'h10;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc, n_ren, n_valid, first_valid_cyc, last_valid_cyc, last_idx, drop_cyc;
    bit pop_now;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_drive();
        bus.empty = (fifo_q.size() == 0);
        bus.rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(next_word);
            pending_q.push_back(next_word);
            next_word = next_word + 8'h1;
        end
        fifo_drive();
    endtask

    // Assign the next k loaded words, in FIFO order, to consumer idx.
    task automatic expect_words(input int idx, input int k);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            e.idx  = idx;
            e.data = pending_q.pop_front();
            exp_q.push_back(e);
        end
    endtask

    task automatic sample();
        exp_t e;
        @(negedge rclk);
        cyc++;
        pop_now = bus.r_en;
        if (bus.r_en) begin
            n_ren++;
            check("no_underflow_read", 32'(bus.empty), 0);
        end
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
        if (bus.rd_valid != '0) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 32'(bus.rd_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_valid_consumer", 32'(bus.rd_valid), 32'(1) << e.idx);
                check("rd_data", 32'(bus.rd_data), 32'(e.data));
                if (last_idx >= 0 && last_idx != e.idx)
                    check("burst_gap_cycles", cyc - last_valid_cyc - 1, 2);
                last_idx = e.idx;
            end
            if (first_valid_cyc == 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
        end
    endtask

    task automatic advance();
        @(posedge rclk);
        #1;
        if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_drive();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic start_test();
        cyc = 0; n_ren = 0; n_valid = 0;
        first_valid_cyc = 0; last_valid_cyc = 0; last_idx = -1;
    endtask

    task automatic end_test(input string tag);
        check({tag, "_all_delivered"}, exp_q.size(), 0);
        check({tag, "_idle"}, 32'(bus.busy), 0);
        exp_q.delete();
        fifo_q.delete();
        pending_q.delete();
        fifo_drive();
    endtask

    task automatic do_reset();
        rrst_n  = 1'b0;
        bus.req = '0;
        fifo_q.delete();
        pending_q.delete();
        fifo_drive();
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rrst_n  = 1'b0;
        bus.req = '0;
        fifo_drive();
        repeat (2) @(posedge rclk);
        #1;
        check("rst_gnt",      32'(bus.gnt),      0);
        check("rst_r_en",     32'(bus.r_en),     0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data",  32'(bus.rd_data),  0);
        check("rst_busy",     32'(bus.busy),     0);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;

        // Single consumer, three words, burst ended by empty.
        start_test();
        load(3);
        expect_words(0, 3);
        bus.req = 4'b0001;
        tick();
        check("t1_gnt",  32'(bus.gnt),  32'h1);
        check("t1_busy", 32'(bus.busy), 1);
        repeat (7) tick();
        check("t1_first_valid_cycle", first_valid_cyc, 3);
        check("t1_last_valid_cycle",  last_valid_cyc,  5);
        check("t1_reads",             n_ren,           3);
        check("t1_valids",            n_valid,         3);
        bus.req = '0;
        end_test("t1");

        // rr_ptr moved to 1: consumer 1 wins over consumer 0.
        start_test();
        load(2);
        expect_words(1, 2);
        bus.req = 4'b0011;
        repeat (8) tick();
        check("t2_valids", n_valid, 2);
        bus.req = '0;
        end_test("t2_rr_ptr");

        // All four requesting, 16 words.
        do_reset();
        start_test();
        load(16);
`ifdef FIFO_RD_BURST_LIMIT_EN
        for (int i = 0; i < 4; i++) expect_words(i, 4);
`else
        expect_words(0, 16);
`endif
        bus.req = 4'b1111;
        repeat (40) tick();
        check("t3_reads",  n_ren,   16);
        check("t3_valids", n_valid, 16);
        bus.req = '0;
        end_test("t3_round_robin");

        // Two requesters alternate only when the burst cap is compiled in.
        do_reset();
        start_test();
        load(16);
`ifdef FIFO_RD_BURST_LIMIT_EN
        for (int i = 0; i < 4; i++) expect_words((i % 2) * 2, 4);
`else
        expect_words(0, 16);
`endif
        bus.req = 4'b0101;
        repeat (40) tick();
        check("t4_valids", n_valid, 16);
        bus.req = '0;
        end_test("t4_burst_cap");

        // FIFO drains after one word while consumer 1 keeps requesting.
        start_test();
        load(1);
        expect_words(1, 1);
        bus.req = 4'b0010;
        repeat (8) tick();
        check("t5_reads",  n_ren,   1);
        check("t5_valids", n_valid, 1);
        bus.req = '0;
        end_test("t5_empty_gate");

        // Reset during a burst to consumer 2; the in-flight word is dropped.
        start_test();
        load(4);
        expect_words(2, 1);
        bus.req = 4'b0100;
        tick();
        tick();
        sample();
        check("t7_r_en_before_reset", 32'(bus.r_en), 1);
        #2 rrst_n = 1'b0;
        #1;
        check("t7_rst_gnt",      32'(bus.gnt),      0);
        check("t7_rst_r_en",     32'(bus.r_en),     0);
        check("t7_rst_rd_valid", 32'(bus.rd_valid), 0);
        check("t7_rst_rd_data",  32'(bus.rd_data),  0);
        check("t7_rst_busy",     32'(bus.busy),     0);
        check("t7_valids_before_reset", n_valid, 1);
        bus.req = '0;
        end_test("t7_reset");
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;

        // After reset rr_ptr is 0, so consumer 1 beats consumer 2.
        start_test();
        load(2);
        expect_words(1, 2);
        bus.req = 4'b0110;
        repeat (8) tick();
        check("t7_restart_valids", n_valid, 2);
        bus.req = '0;
        end_test("t7_restart");

        // Consumer 3 drops req after its second read.
        start_test();
        load(4);
        expect_words(3, 2);
        bus.req  = 4'b1000;
        drop_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (n_ren == 2 && drop_cyc == 0) begin
                bus.req  = '0;
                drop_cyc = cyc;
            end
        end
        check("t6_reads",             n_ren,          2);
        check("t6_valids",            n_valid,        2);
        check("t6_last_valid_cycle",  last_valid_cyc, drop_cyc + 1);
        end_test("t6_req_drop");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
